multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
// Multi-cycle sequencer for the MIPS datapath: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// driving per-cycle datapath enables and a req/ready handshake to the shared instruction/data memory.
// Uses the opcode set and size encoding of the single-cycle decoder (MemRead/MemWrite 1=byte, 2=half, 3=word).
// It sits between the instruction register and the datapath's muxes, ALU and register file.
// PARAMETERS
// MEM_TIMEOUT  16  max mem_ready wait cycles per access before the access is aborted.
// CNT_W        32  width of the retired-instruction counter.
// PORTS
// clk          in   1      clock, rising edge
// rst          in   1      asynchronous reset, active-high
// opcode       in   6      IR[31:26], valid from DECODE onward
// zero         in   1      ALU zero flag, sampled in BRANCH state
// mem_ready    in   1      memory completes the current access this cycle
// mem_req      out  1      memory access request, held until mem_ready or timeout
// mem_we       out  1      write access (with mem_req)
// mem_size     out  2      1=byte, 2=half, 3=word
// iord         out  1      0=address from PC, 1=address from ALUOut
// ir_write     out  1      load IR
// pc_write     out  1      unconditional PC load
// pc_src       out  2      0=ALU result, 1=ALUOut (branch target), 2=jump target
// alu_src_a    out  1      0=PC, 1=rs
// alu_src_b    out  2      0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
// alu_op       out  2      00=add, 01=sub, 10=funct/ALUOpFinal
// reg_write    out  1      register-file write strobe
// reg_dst      out  2      0=rt, 1=rd, 2=$31
// mem_to_reg   out  2      0=ALUOut, 1=MDR, 2=PC (jal link)
// illegal      out  1      one-cycle pulse: unknown opcode decoded
// bus_err      out  1      one-cycle pulse: memory timeout
// retired      out  CNT_W  count of instructions completed
// BEHAVIOUR
// - Reset (async): state=FETCH, wait counter=0, retired=0, every other output 0.
// - All outputs are Moore functions of state (bus_err/illegal/retired registered); no opcode-to-output comb path except DECODE.
// - FETCH: mem_req=1, iord=0, mem_size=3; stays while !mem_ready; on mem_ready: ir_write=1, pc_write=1,
//   alu_src_a=0, alu_src_b=1, pc_src=0 (PC+4) -> DECODE. Minimum instruction = 3 cycles.
// - DECODE: alu_src_a=0, alu_src_b=3, alu_op=00 (branch target). Next by opcode: 000000->EXEC_R;
//   addi/andi/ori/slti/lui->EXEC_I; lb/lh/lw/sb/sh/sw->MEM_ADDR; beq/bne->BRANCH; j->JUMP; jal->JAL;
//   other->FETCH with illegal=1 for one cycle (instruction not counted).
// - EXEC_R: a=1,b=0,op=10 -> WB_ALU (reg_dst=1). EXEC_I: a=1,b=2,op=10 -> WB_ALU (reg_dst=0).
// - WB_ALU: reg_write=1, mem_to_reg=0 -> FETCH, retired++.
// - MEM_ADDR: a=1,b=2,op=00 -> MEM_RD (loads) / MEM_WR (stores). mem_size latched from opcode[1:0]+1.
// - MEM_RD: mem_req=1, iord=1, mem_we=0; on mem_ready -> WB_MEM. WB_MEM: reg_write=1, mem_to_reg=1,
//   reg_dst=0 -> FETCH, retired++. MEM_WR: mem_req=1, iord=1, mem_we=1; on mem_ready -> FETCH, retired++.
// - BRANCH: a=1,b=0,op=01; pc_src=1; pc_write=1 iff (beq & zero)|(bne & !zero) -> FETCH, retired++.
// - JUMP: pc_src=2, pc_write=1 -> FETCH, retired++. JAL: as JUMP plus reg_write=1, reg_dst=2, mem_to_reg=2.
// - Handshake: mem_req, iord, mem_we, mem_size stable from assertion until mem_ready cycle; deasserted next cycle.
// - Timeout: wait counter clears on entering any memory state, increments each cycle mem_ready=0;
//   when it reaches MEM_TIMEOUT: bus_err=1 one cycle, no ir_write/pc_write/reg_write, -> FETCH (PC unchanged).
//   mem_ready on the same cycle as the limit wins (access completes, no bus_err).
// - retired wraps modulo 2^CNT_W. Reset mid-instruction aborts immediately; no partial writeback after rst.
// TESTING
// 1 rst=1 then release, mem_ready tied 1, opcode=000000 -> states FETCH,DECODE,EXEC_R,WB_ALU; reg_write@cycle4, retired=1.
// 2 lw (100011), mem_ready low 3 cycles in MEM_RD -> mem_req held 4 cycles, mem_size=3, WB_MEM reg_write, 5+3 cycles total.
// 3 beq with zero=1 -> pc_write=1,pc_src=1 in BRANCH; with zero=0 -> pc_write=0; bne inverse; retired increments both.
// 4 opcode=111111 -> illegal pulse 1 cycle after DECODE, back to FETCH, retired unchanged, no reg_write.
// 5 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_err at 5th FETCH cycle, ir_write/pc_write never 1, FETCH re-entered.
// 6 jal with rst asserted during JAL -> all outputs 0 same cycle (async), state FETCH, retired=0; sb gives mem_size=1, mem_we=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back states and drives the datapath controls
// plus a req/ready handshake to the shared memory. Memory accesses that
// wait too long are aborted with a bus error.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_size,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0]   LIMIT  = WCW'(MEM_TIMEOUT - 1);
  localparam logic [WCW-1:0]   ONE_W  = WCW'(1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR,
    MEM_RD, MEM_WR, WB_MEM, BRANCH, JUMP, JAL
  } state_t;

  state_t           state_reg, state_next;
  logic [WCW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [1:0]       size_reg, size_next;
  logic             is_r_reg, is_r_next;
  logic             is_bne_reg, is_bne_next;
  logic             illegal_reg, bus_err_reg;
  logic [CNT_W-1:0] retired_reg;
  logic             in_mem, abort, retire, ill_det;

  assign illegal = illegal_reg;
  assign bus_err = bus_err_reg;
  assign retired = retired_reg;

  // State, wait counter, latched instruction attributes and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= '0;
      size_reg     <= '0;
      is_r_reg     <= 1'b0;
      is_bne_reg   <= 1'b0;
      illegal_reg  <= 1'b0;
      bus_err_reg  <= 1'b0;
      retired_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      size_reg     <= size_next;
      is_r_reg     <= is_r_next;
      is_bne_reg   <= is_bne_next;
      illegal_reg  <= ill_det;
      bus_err_reg  <= abort;
      if (retire) retired_reg <= retired_reg + ONE_C;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_next  = state_reg;
    size_next   = size_reg;
    is_r_next   = is_r_reg;
    is_bne_next = is_bne_reg;
    ill_det     = 1'b0;
    retire      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_size    = 2'd0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_op      = 2'd0;
    reg_write   = 1'b0;
    reg_dst     = 2'd0;
    mem_to_reg  = 2'd0;

    // The counter is zero on entry to every memory state because it is
    // cleared whenever an access completes, aborts or no access is pending.
    in_mem = (state_reg == FETCH) || (state_reg == MEM_RD) || (state_reg == MEM_WR);
    // A ready on the limit cycle still completes the access.
    abort  = in_mem && !mem_ready && (wait_cnt_reg == LIMIT);
    wait_cnt_next = (in_mem && !mem_ready && !abort) ? wait_cnt_reg + ONE_W : '0;

    case (state_reg)
      FETCH: begin
        mem_req  = 1'b1;
        mem_size = 2'd3;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = 2'd1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        alu_src_b   = 2'd3;
        is_r_next   = (opcode == 6'b000000);
        is_bne_next = opcode[0];
        case (opcode)
          6'b000000:                                  state_next = EXEC_R;
          6'b001000, 6'b001100, 6'b001101,
          6'b001010, 6'b001111:                       state_next = EXEC_I;
          6'b100000, 6'b100001, 6'b100011,
          6'b101000, 6'b101001, 6'b101011:            state_next = MEM_ADDR;
          6'b000100, 6'b000101:                       state_next = BRANCH;
          6'b000010:                                  state_next = JUMP;
          6'b000011:                                  state_next = JAL;
          default: begin
            ill_det    = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'd2;
        reg_dst    = 2'd1;
        state_next = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        alu_op     = 2'd2;
        state_next = WB_ALU;
      end
      WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = is_r_reg ? 2'd1 : 2'd0;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        // Opcode low bits 00/01/11 select byte/half/word.
        size_next  = (opcode[1:0] == 2'b11) ? 2'd3 : opcode[1:0] + 2'd1;
        state_next = opcode[3] ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_size = size_reg;
        if (mem_ready)  state_next = WB_MEM;
        else if (abort) state_next = FETCH;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEM_WR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_we   = 1'b1;
        mem_size = size_reg;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = FETCH;
        end else if (abort) begin
          state_next = FETCH;
        end
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'd1;
        pc_src     = 2'd1;
        pc_write   = is_bne_reg ? !zero : zero;
        retire     = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        pc_src     = 2'd2;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        pc_src     = 2'd2;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        retire     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // Reset silences every control at once, without waiting for a clock.
    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_size   = 2'd0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 2'd0;
      reg_write  = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level model expands
// each instruction into its expected per-cycle control pattern; a vector table,
// a hand-written mid-instruction reset and random instructions drive it.
module tb_multicycle_ctrl;

  localparam int T = 4;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                         OP_ORI = 6'b001101, OP_SLTI = 6'b001010, OP_LUI = 6'b001111,
                         OP_LB = 6'b100000, OP_LH = 6'b100001, OP_LW = 6'b100011,
                         OP_SB = 6'b101000, OP_SH = 6'b101001, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                         OP_JAL = 6'b000011;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_size;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } outs_t;

  typedef struct {
    logic  rdy;
    outs_t outs;
    logic  ill;
    logic  berr;
    logic  ret;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         fd;
    int         md;
    int         dret;
    logic       ill;
    logic       berr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero, mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, reg_write;
  logic        illegal, bus_err;
  logic [1:0]  mem_size, pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic [31:0] retired;
  outs_t       act;

  int          n_cmp = 0, n_bad = 0;
  cyc_t        sched[$];
  logic        exp_ill = 1'b0, exp_berr = 1'b0;
  logic [31:0] exp_ret = '0;
  vec_t        tbl[16];
  logic [5:0]  legal_ops[16];

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  assign act = {mem_req, mem_we, mem_size, iord, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, expv, $time);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic void put(input logic rdy, input outs_t o, input logic ill,
                              input logic berr, input logic ret);
    cyc_t c;
    c.rdy = rdy; c.outs = o; c.ill = ill; c.berr = berr; c.ret = ret;
    sched.push_back(c);
  endfunction

  // One memory access that sees d not-ready cycles before ready; d >= T aborts.
  function automatic bit mem_access(input int d, input outs_t ow, input outs_t od, input logic ret_done);
    int n = (d < T) ? d : T;
    for (int i = 0; i < n; i++) put(1'b0, ow, 1'b0, (d >= T) && (i == n - 1), 1'b0);
    if (d >= T) return 1'b0;
    put(1'b1, od, 1'b0, 1'b0, ret_done);
    return 1'b1;
  endfunction

  // Instruction-level reference: expected controls for each cycle of one instruction.
  function automatic void build(input logic [5:0] op, input logic z, input int fd, input int md);
    outs_t o, od;
    logic [1:0] sz;
    logic st;
    o = '0; o.mem_req = 1'b1; o.mem_size = 2'd3;
    od = o; od.ir_write = 1'b1; od.pc_write = 1'b1; od.alu_src_b = 2'd1;
    if (!mem_access(fd, o, od, 1'b0)) return;
    o = '0; o.alu_src_b = 2'd3;
    case (op)
      OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI, OP_LB, OP_LH, OP_LW,
      OP_SB, OP_SH, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: put(rnd(), o, 1'b0, 1'b0, 1'b0);
      default: begin
        put(rnd(), o, 1'b1, 1'b0, 1'b0);
        return;
      end
    endcase
    o = '0;
    case (op)
      OP_R: begin
        o.alu_src_a = 1'b1; o.alu_op = 2'd2; o.reg_dst = 2'd1;
        put(rnd(), o, 1'b0, 1'b0, 1'b0);
        o = '0; o.reg_write = 1'b1; o.reg_dst = 2'd1;
        put(rnd(), o, 1'b0, 1'b0, 1'b1);
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
        o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_op = 2'd2;
        put(rnd(), o, 1'b0, 1'b0, 1'b0);
        o = '0; o.reg_write = 1'b1;
        put(rnd(), o, 1'b0, 1'b0, 1'b1);
      end
      OP_BEQ, OP_BNE: begin
        o.alu_src_a = 1'b1; o.alu_op = 2'd1; o.pc_src = 2'd1;
        o.pc_write = (op == OP_BEQ) ? z : !z;
        put(rnd(), o, 1'b0, 1'b0, 1'b1);
      end
      OP_J, OP_JAL: begin
        o.pc_src = 2'd2; o.pc_write = 1'b1;
        if (op == OP_JAL) begin
          o.reg_write = 1'b1; o.reg_dst = 2'd2; o.mem_to_reg = 2'd2;
        end
        put(rnd(), o, 1'b0, 1'b0, 1'b1);
      end
      default: begin
        st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        sz = (op == OP_LB || op == OP_SB) ? 2'd1 : (op == OP_LH || op == OP_SH) ? 2'd2 : 2'd3;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'd2;
        put(rnd(), o, 1'b0, 1'b0, 1'b0);
        o = '0; o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = st; o.mem_size = sz;
        if (!mem_access(md, o, o, st)) return;
        if (!st) begin
          o = '0; o.reg_write = 1'b1; o.mem_to_reg = 2'd1;
          put(rnd(), o, 1'b0, 1'b0, 1'b1);
        end
      end
    endcase
  endfunction

  // Entered and left just after a rising edge.
  task automatic run(input logic [5:0] op, input logic z, input int fd, input int md);
    int k = 0;
    sched.delete();
    build(op, z, fd, md);
    opcode = op;
    zero   = z;
    foreach (sched[i]) begin
      mem_ready = sched[i].rdy;
      @(negedge clk);
      chk($sformatf("outs op=%b cyc=%0d", op, k), 64'(act), 64'(sched[i].outs));
      chk($sformatf("illegal op=%b cyc=%0d", op, k), 64'(illegal), 64'(exp_ill));
      chk($sformatf("bus_err op=%b cyc=%0d", op, k), 64'(bus_err), 64'(exp_berr));
      chk($sformatf("retired op=%b cyc=%0d", op, k), 64'(retired), 64'(exp_ret));
      exp_ill  = sched[i].ill;
      exp_berr = sched[i].berr;
      exp_ret  = exp_ret + 32'(sched[i].ret);
      k++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] base;
    legal_ops = '{OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI, OP_LB, OP_LH,
                  OP_LW, OP_SB, OP_SH, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL};
    //          op        z     fd  md  dret ill   berr
    tbl[0]  = '{OP_R,    1'b0, 0,  0,  1,   1'b0, 1'b0};
    tbl[1]  = '{OP_LW,   1'b0, 0,  3,  1,   1'b0, 1'b0};
    tbl[2]  = '{OP_BEQ,  1'b1, 0,  0,  1,   1'b0, 1'b0};
    tbl[3]  = '{OP_BEQ,  1'b0, 0,  0,  1,   1'b0, 1'b0};
    tbl[4]  = '{OP_BNE,  1'b1, 0,  0,  1,   1'b0, 1'b0};
    tbl[5]  = '{OP_BNE,  1'b0, 0,  0,  1,   1'b0, 1'b0};
    tbl[6]  = '{6'h3f,   1'b0, 0,  0,  0,   1'b1, 1'b0};
    tbl[7]  = '{OP_R,    1'b0, 9,  0,  0,   1'b0, 1'b1};
    tbl[8]  = '{OP_SB,   1'b0, 1,  0,  1,   1'b0, 1'b0};
    tbl[9]  = '{OP_ADDI, 1'b0, 2,  0,  1,   1'b0, 1'b0};
    tbl[10] = '{OP_J,    1'b0, 0,  0,  1,   1'b0, 1'b0};
    tbl[11] = '{OP_JAL,  1'b0, 0,  0,  1,   1'b0, 1'b0};
    tbl[12] = '{OP_SW,   1'b0, 0,  7,  0,   1'b0, 1'b1};
    tbl[13] = '{OP_LH,   1'b0, 0,  3,  1,   1'b0, 1'b0};
    tbl[14] = '{OP_LUI,  1'b0, 3,  0,  1,   1'b0, 1'b0};
    tbl[15] = '{OP_LB,   1'b0, 0,  4,  0,   1'b0, 1'b1};

    rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outs", 64'(act), 64'(0));
    chk("reset retired", 64'(retired), 64'(0));
    chk("reset pulses", 64'({illegal, bus_err}), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Vector table: per-cycle model plus end-of-instruction table checks.
    for (int v = 0; v < 16; v++) begin
      base = exp_ret;
      run(tbl[v].op, tbl[v].z, tbl[v].fd, tbl[v].md);
      mem_ready = 1'b0;
      #1;
      chk($sformatf("tbl%0d retired", v), 64'(retired), 64'(base + 32'(tbl[v].dret)));
      chk($sformatf("tbl%0d illegal", v), 64'(illegal), 64'(tbl[v].ill));
      chk($sformatf("tbl%0d bus_err", v), 64'(bus_err), 64'(tbl[v].berr));
      chk($sformatf("tbl%0d back in fetch", v), 64'({mem_req, iord, mem_we, mem_size}), 64'(5'b10011));
      $display("vector %0d op=%b fd=%0d md=%0d retired=%0d", v, tbl[v].op, tbl[v].fd, tbl[v].md, retired);
    end

    // Reset in the middle of JAL: controls drop at once, count clears.
    opcode = OP_JAL; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("jal fetch ir_write", 64'(ir_write), 64'(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("jal link write", 64'({reg_write, reg_dst, mem_to_reg, pc_write}), 64'(6'b110101));
    #1 rst = 1'b1;
    #1;
    chk("async reset outs", 64'(act), 64'(0));
    chk("async reset retired", 64'(retired), 64'(0));
    @(posedge clk); #1;
    chk("reset held outs", 64'(act), 64'(0));
    rst = 1'b0;
    exp_ret = '0; exp_ill = 1'b0; exp_berr = 1'b0;
    $display("mid-JAL reset done retired=%0d", retired);
    run(OP_SB, 1'b0, 0, 0);
    $display("post-reset sb retired=%0d", retired);

    // Random instructions with random ready latencies (some timing out).
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      int fd, md;
      op = ($urandom_range(7, 0) == 0) ? 6'($urandom) : legal_ops[$urandom_range(15, 0)];
      fd = ($urandom_range(7, 0) == 0) ? $urandom_range(6, 3) : $urandom_range(2, 0);
      md = ($urandom_range(7, 0) == 0) ? $urandom_range(6, 3) : $urandom_range(2, 0);
      run(op, rnd(), fd, md);
      $display("random %0d op=%b fd=%0d md=%0d retired=%0d", n, op, fd, md, retired);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
